// File: rtl/if_prefetch_buf_pkg.sv
// rtl/if_prefetch_buf_pkg.sv - shared constants and entry type for the instruction prefetch buffer
package if_prefetch_buf_pkg;
  localparam int              XLEN             = 32;
  localparam int              INSTR_BYTES      = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_entry_t;
endpackage

// File: rtl/if_prefetch_buf_if.sv
// rtl/if_prefetch_buf_if.sv - instruction memory request/response channel
interface if_prefetch_buf_if;
  import if_prefetch_buf_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );
endinterface

// File: rtl/if_prefetch_buf_ifq_fifo.sv
// rtl/if_prefetch_buf_ifq_fifo.sv - synchronous FIFO of if_entry_t with clear and occupancy count
module ifq_fifo
  import if_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  if_entry_t                i_data,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output if_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/if_prefetch_buf.sv
// rtl/if_prefetch_buf.sv - sequential instruction prefetcher with redirect flush
// Define IF_PREFETCH_BYPASS_EN to forward a live response to the outputs when the FIFO is empty.
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_pcsrc,
  input  logic [XLEN-1:0]   i_pctarget,
  output logic              o_instr_valid,
  output logic [XLEN-1:0]   o_instr,
  output logic [XLEN-1:0]   o_instr_pc,
  if_prefetch_buf_if.master mem
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_stale;
  logic            r_epoch;
  logic            r_run;
  if_entry_t       r_hold;

  if_entry_t       w_q_head;
  if_entry_t       w_tag_head;
  if_entry_t       w_tag_wdata;
  if_entry_t       w_rsp_entry;
  logic [CW-1:0]   w_q_count;
  logic [CW-1:0]   w_tag_count;
  logic [CW-1:0]   w_pool;
  logic [SW-1:0]   w_credit;
  logic            w_q_full, w_q_empty, w_tag_full, w_tag_empty;
  logic            w_req_hs, w_rsp_live, w_bypass, w_pop, w_q_push;

  // The tag queue depth equals the outstanding count; stale responses still hold credit.
  assign w_credit = SW'(w_q_count) + SW'(w_tag_count) + SW'(r_stale);
  assign w_pool   = r_stale + w_tag_count;

  assign mem.mem_req_valid = r_run && !i_pcsrc && !w_tag_full && (w_credit < SW'(DEPTH));
  assign mem.mem_req_addr  = r_fetch_pc;
  assign w_req_hs          = mem.mem_req_valid && mem.mem_req_ready;

  assign w_tag_wdata = '{instr: {{(XLEN-1){1'b0}}, r_epoch}, pc: r_fetch_pc};
  assign w_rsp_entry = '{instr: mem.mem_rsp_data, pc: w_tag_head.pc};
  assign w_rsp_live  = mem.mem_rsp_valid && (r_stale == '0) && !w_tag_empty &&
                       (w_tag_head.instr == {{(XLEN-1){1'b0}}, r_epoch});

`ifdef IF_PREFETCH_BYPASS_EN
  assign w_bypass = w_q_empty && w_rsp_live;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    o_instr_valid = !w_q_empty;
    o_instr       = w_q_empty ? r_hold.instr : w_q_head.instr;
    o_instr_pc    = w_q_empty ? r_hold.pc    : w_q_head.pc;
    if (w_bypass) begin
      o_instr_valid = 1'b1;
      o_instr       = w_rsp_entry.instr;
      o_instr_pc    = w_rsp_entry.pc;
    end
  end

  assign w_pop    = o_instr_valid && !i_stall;
  assign w_q_push = w_rsp_live && !i_pcsrc && !(w_bypass && w_pop);

  ifq_fifo #(.DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_q_push),
    .i_data  (w_rsp_entry),
    .i_pop   (w_pop),
    .i_clear (i_pcsrc),
    .o_head  (w_q_head),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  ifq_fifo #(.DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_hs),
    .i_data  (w_tag_wdata),
    .i_pop   (w_rsp_live),
    .i_clear (i_pcsrc),
    .o_head  (w_tag_head),
    .o_count (w_tag_count),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_stale    <= '0;
      r_epoch    <= 1'b0;
      r_run      <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_run <= 1'b1;
      if (o_instr_valid) begin
        r_hold <= '{instr: o_instr, pc: o_instr_pc};
      end
      if (i_pcsrc) begin
        // A response arriving in the redirect cycle retires one of the requests being orphaned.
        r_fetch_pc <= i_pctarget & ~XLEN'(3);
        r_epoch    <= ~r_epoch;
        r_stale    <= (mem.mem_rsp_valid && (w_pool != '0)) ? w_pool - CW'(1) : w_pool;
      end else begin
        if (w_req_hs) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
        end
        if (mem.mem_rsp_valid && (r_stale != '0)) begin
          r_stale <= r_stale - CW'(1);
        end
      end
    end
  end

  a_no_drop: assert property (@(posedge clk) disable iff (rst) !(w_q_push && w_q_full && !w_pop));
endmodule
